// File: rtl/ha_array_pkg.sv
// Shared geometry and FSM state type for the ha_array partial-product reducer.
package ha_array_pkg;

   localparam int unsigned NROWS     = 4;
   localparam int unsigned TW        = 9;
   localparam int unsigned BW        = 7;
   localparam int unsigned B_SHIFT   = 2;
   localparam int unsigned ROW_SHIFT = 2;
   localparam int unsigned PW        = 16;
   localparam int unsigned ROWV_W    = TW + 1;
   localparam int unsigned ACC_W     = PW + 1;
   localparam int unsigned ROW_W     = $clog2(NROWS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ha_row_value.sv
// Value of one half-adder-compressed row: t + (b << B_SHIFT).
module ha_row_value
   import ha_array_pkg::*;
(
   input  logic [TW-1:0]     t,
   input  logic [BW-1:0]     b,
   output logic [ROWV_W-1:0] row_val
);

   always_comb begin
      row_val = ROWV_W'(t) + (ROWV_W'(b) << B_SHIFT);
   end

endmodule

// File: rtl/ha_array_reducer.sv
// Serially reduces the four ha_array rows into a 16-bit product, one row per cycle,
// with valid/ready handshakes on the row-set input and the product output.
module ha_array_reducer
   import ha_array_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NROWS*TW-1:0]   ha_t,
   input  logic [NROWS*BW-1:0]   ha_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PW-1:0]         out_prod,
   output logic                  out_ovf
);

   state_t                state;
   logic [NROWS*TW-1:0]   cap_t;
   logic [NROWS*BW-1:0]   cap_b;
   logic [ROW_W-1:0]      row;
   logic [ACC_W-1:0]      acc;
   logic                  ovf;

   logic [TW-1:0]         sel_t;
   logic [BW-1:0]         sel_b;
   logic [ROWV_W-1:0]     row_val;
   logic [ACC_W-1:0]      addend;
   logic [ACC_W:0]        sum;

   always_comb begin
      sel_t = cap_t[row*TW +: TW];
      sel_b = cap_b[row*BW +: BW];
   end

   ha_row_value u_row_value (
      .t       (sel_t),
      .b       (sel_b),
      .row_val (row_val)
   );

   // Extra top bit keeps the carry out of the 17-bit accumulator observable.
   always_comb begin
      addend = ACC_W'(row_val) << (ROW_SHIFT * row);
      sum    = {1'b0, acc} + {1'b0, addend};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cap_t <= '0;
         cap_b <= '0;
         row   <= '0;
         acc   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cap_t <= ha_t;
                  cap_b <= ha_b;
                  acc   <= '0;
                  ovf   <= 1'b0;
                  row   <= '0;
                  state <= ACC;
               end
            end
            ACC: begin
               acc <= sum[ACC_W-1:0];
               ovf <= ovf | sum[ACC_W] | sum[PW];
               row <= row + 1'b1;
               if (row == ROW_W'(NROWS - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      out_prod  = acc[PW-1:0];
      out_ovf   = ovf;
   end

endmodule

// File: tb/tb_ha_array_reducer.sv
// Directed-vector bench for ha_array_reducer with hand-computed products.
module tb_ha_array_reducer;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [35:0]   ha_t;
   logic [27:0]   ha_b;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_prod;
   logic          out_ovf;

   int unsigned   n_cmp = 0;
   int unsigned   n_err = 0;

   always #5 clk = ~clk;

   ha_array_reducer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ha_t      (ha_t),
      .ha_b      (ha_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .out_ovf   (out_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] pt(input logic [8:0] t0, input logic [8:0] t1,
                                      input logic [8:0] t2, input logic [8:0] t3);
      return {t3, t2, t1, t0};
   endfunction

   function automatic logic [27:0] pb(input logic [6:0] b0, input logic [6:0] b1,
                                      input logic [6:0] b2, input logic [6:0] b3);
      return {b3, b2, b1, b0};
   endfunction

   // Offers one row set and checks the latency, result and return to IDLE.
   task automatic run_case(input string tag, input logic [35:0] t, input logic [27:0] b,
                           input logic [15:0] ep, input logic eo);
      int unsigned n;
      @(negedge clk);
      ha_t = t; ha_b = b; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ha_t = ~t; ha_b = ~b;
      repeat (3) @(posedge clk);
      #1 chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_prod"}, 32'(out_prod), 32'(ep));
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned hs_cyc [3];
      int unsigned hs_n;
      int unsigned n;
      logic        held;

      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      ha_t = '1; ha_b = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_prod", 32'(out_prod), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      run_case("zero", '0, '0, 16'h0000, 1'b0);
      run_case("r0t0", pt(9'h001, 9'h0, 9'h0, 9'h0), '0, 16'h0001, 1'b0);
      run_case("r3b6", '0, pb(7'h0, 7'h0, 7'h0, 7'h40), 16'h4000, 1'b0);
      run_case("ones", '1, '1, 16'h5257, 1'b1);
      run_case("ff01", pt(9'h001, 9'h001, 9'h001, 9'h001), '0, 16'h0055, 1'b0);
      run_case("mix", pt(9'h123, 9'h0, 9'h0, 9'h0), pb(7'h0, 7'h0, 7'h55, 7'h0), 16'h1663, 1'b0);

      // Back-to-back row sets with the sink always ready.
      @(negedge clk);
      ha_t = pt(9'h001, 9'h001, 9'h001, 9'h001); ha_b = '0;
      in_valid = 1'b1; out_ready = 1'b1;
      hs_n = 0;
      for (int unsigned i = 0; i < 24; i++) begin
         @(negedge clk);
         if (out_valid && hs_n < 3) begin
            hs_cyc[hs_n] = i;
            hs_n++;
            chk("b2b_prod", 32'(out_prod), 32'h55);
         end
      end
      in_valid = 1'b0;
      chk("b2b_count", hs_n, 3);
      if (hs_n == 3) begin
         chk("b2b_period_a", hs_cyc[1] - hs_cyc[0], 6);
         chk("b2b_period_b", hs_cyc[2] - hs_cyc[1], 6);
      end
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_drain", 32'(in_ready), 32'd1);

      // Backpressure held for 10 cycles in DONE.
      @(negedge clk);
      ha_t = '1; ha_b = '1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", 32'(out_valid), 32'd1);
      held = 1'b1;
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!(out_valid && out_prod == 16'h5257 && out_ovf && !in_ready)) held = 1'b0;
      end
      chk("bp_hold", 32'(held), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_ready", 32'(in_ready), 32'd1);

      // Reset asserted in ACC after two rows have been added.
      @(negedge clk);
      ha_t = '1; ha_b = '1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_prod", 32'(out_prod), 32'd0);
      chk("mid_rst_ovf", 32'(out_ovf), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      ha_t = pt(9'h0, 9'h0AB, 9'h0, 9'h0); ha_b = '0; in_valid = 1'b1;
      held = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) held = 1'b0;
      end
      chk("mid_rst_quiet", 32'(held), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_accept", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("post_rst_valid_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_prod", 32'(out_prod), 32'h02AC);
      chk("post_rst_ovf", 32'(out_ovf), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
